// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier with signed/fractional modes and an
// optional MR accumulate stage enabled by defining MUL_ITER_ACC_EN.
module mul_iter #(
    parameter int SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SIZE-1:0]       mul_a,
    input  logic [SIZE-1:0]       mul_b,
    input  logic                  a_signed,
    input  logic                  b_signed,
    input  logic                  ps_mul_IbF,
    input  logic [1:0]            acc_op,
    input  logic [SIZE*5/2-1:0]   mr_in,
    output logic                  busy,
    output logic                  done,
    output logic [SIZE*5/2-1:0]   mul40_out_data
);

    localparam int RW = SIZE * 5 / 2;
    localparam int PW = 2 * SIZE;
    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [PW-1:0]   mcand_reg;
    logic [PW-1:0]   prod_reg;
    logic [SIZE-1:0] mplier_reg;
    logic            neg_reg;
    logic            sat_reg;
    logic            frac_reg;
    logic            sext_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [RW-1:0]   out_reg;

    // Operand magnitudes and mode flags, evaluated at capture time
    logic [SIZE-1:0] mag_a;
    logic [SIZE-1:0] mag_b;
    logic [SIZE-1:0] min_val;
    logic            neg_next;
    logic            sat_next;

    assign min_val  = {1'b1, {(SIZE-1){1'b0}}};
    assign mag_a    = (a_signed && mul_a[SIZE-1]) ? (~mul_a + 1'b1) : mul_a;
    assign mag_b    = (b_signed && mul_b[SIZE-1]) ? (~mul_b + 1'b1) : mul_b;
    assign neg_next = (a_signed & mul_a[SIZE-1]) ^ (b_signed & mul_b[SIZE-1]);
    assign sat_next = ps_mul_IbF & a_signed & b_signed &
                      (mul_a == min_val) & (mul_b == min_val);

    logic [PW-1:0] prod_signed;
    logic [PW-1:0] prod_scaled;
    logic [RW-1:0] prod_ext;
    logic [RW-1:0] result_next;

    assign prod_signed = neg_reg ? (~prod_reg + 1'b1) : prod_reg;

    // Fractional mode drops the redundant sign bit; -1.0 * -1.0 saturates
    always_comb begin
        prod_scaled = prod_signed;
        if (frac_reg) begin
            prod_scaled = {prod_signed[PW-2:0], 1'b0};
        end
        if (sat_reg) begin
            prod_scaled = {1'b0, {(PW-1){1'b1}}};
        end
    end

    assign prod_ext = sext_reg ? {{(RW-PW){prod_scaled[PW-1]}}, prod_scaled}
                               : {{(RW-PW){1'b0}}, prod_scaled};

`ifdef MUL_ITER_ACC_EN
    logic [1:0]    acc_op_reg;
    logic [RW-1:0] mr_reg;

    always_comb begin
        case (acc_op_reg)
            2'b01:   result_next = mr_reg + prod_ext;
            2'b10:   result_next = mr_reg - prod_ext;
            default: result_next = prod_ext;
        endcase
    end
`else
    logic acc_unused;
    assign acc_unused  = ^{acc_op, mr_in};
    assign result_next = prod_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            prod_reg   <= '0;
            mplier_reg <= '0;
            neg_reg    <= 1'b0;
            sat_reg    <= 1'b0;
            frac_reg   <= 1'b0;
            sext_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            out_reg    <= '0;
`ifdef MUL_ITER_ACC_EN
            acc_op_reg <= 2'b00;
            mr_reg     <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg  <= {{(PW-SIZE){1'b0}}, mag_a};
                        mplier_reg <= mag_b;
                        prod_reg   <= '0;
                        cnt_reg    <= '0;
                        neg_reg    <= neg_next;
                        sat_reg    <= sat_next;
                        frac_reg   <= ps_mul_IbF;
                        sext_reg   <= a_signed | b_signed;
`ifdef MUL_ITER_ACC_EN
                        acc_op_reg <= acc_op;
                        mr_reg     <= mr_in;
`endif
                        busy_reg   <= 1'b1;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    if (abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        if (mplier_reg[0]) begin
                            prod_reg <= prod_reg + mcand_reg;
                        end
                        mcand_reg  <= {mcand_reg[PW-2:0], 1'b0};
                        mplier_reg <= mplier_reg >> 1;
                        if (cnt_reg == CNT_LAST) begin
                            cnt_reg   <= '0;
                            state_reg <= FIN;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                FIN: begin
                    if (!abort) begin
                        out_reg  <= result_next;
                        done_reg <= 1'b1;
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign mul40_out_data = out_reg;

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: expected results are queued at issue time
// and compared when done pulses; latency, busy, abort and reset are checked inline.
module tb_mul_iter;

`ifdef MUL_ITER_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        a_signed;
    logic        b_signed;
    logic        ps_mul_IbF;
    logic [1:0]  acc_op;
    logic [39:0] mr_in;
    logic        busy;
    logic        done;
    logic [39:0] mul40_out_data;

    int n_vec = 0;
    int n_err = 0;
    logic [39:0] sb[$];

    mul_iter #(.SIZE(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .a_signed       (a_signed),
        .b_signed       (b_signed),
        .ps_mul_IbF     (ps_mul_IbF),
        .acc_op         (acc_op),
        .mr_in          (mr_in),
        .busy           (busy),
        .done           (done),
        .mul40_out_data (mul40_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Reference: full-precision integer product, then scale/saturate/extend/accumulate
    function automatic logic [39:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic as, input logic bs, input logic fr,
                                          input logic [1:0] op, input logic [39:0] mr);
        longint pa;
        longint pb;
        longint p;
        logic [31:0] p32;
        logic [39:0] r;
        pa = as ? longint'($signed(a)) : longint'(a);
        pb = bs ? longint'($signed(b)) : longint'(b);
        p = pa * pb;
        if (fr) p = p * 2;
        p32 = p[31:0];
        if (fr && as && bs && a == 16'h8000 && b == 16'h8000) p32 = 32'h7FFF_FFFF;
        r = (as || bs) ? {{8{p32[31]}}, p32} : {8'h00, p32};
        if (ACC_EN && op == 2'b01) r = mr + r;
        else if (ACC_EN && op == 2'b10) r = mr - r;
        return r;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic as, input logic bs, input logic fr,
                          input logic [1:0] op, input logic [39:0] mr,
                          input bit no_wait, input int poke_edge, input int abort_edge,
                          output bit got, output logic [39:0] val,
                          output int edges, output int busy_cyc);
        if (!no_wait) @(negedge clk);
        mul_a = a; mul_b = b; a_signed = as; b_signed = bs;
        ps_mul_IbF = fr; acc_op = op; mr_in = mr; start = 1'b1;
        if (abort_edge == 0) sb.push_back(model(a, b, as, bs, fr, op, mr));
        got = 1'b0; val = '0; edges = 0; busy_cyc = 0;
        while (!got && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cyc++;
            if (done) begin
                got = 1'b1;
                val = mul40_out_data;
            end
            if (edges == 1) begin
                // Operands are captured; scramble them to prove they are not reused
                start = 1'b0;
                {mul_a, mul_b} = $urandom;
                {a_signed, b_signed, ps_mul_IbF, acc_op} = 5'($urandom);
                mr_in = {8'($urandom), $urandom};
            end
            if (poke_edge != 0 && edges == poke_edge) start = 1'b1;
            if (poke_edge != 0 && edges == poke_edge + 1) start = 1'b0;
            if (abort_edge != 0 && edges == abort_edge) abort = 1'b1;
            if (abort_edge != 0 && edges == abort_edge + 1) abort = 1'b0;
        end
        start = 1'b0;
        abort = 1'b0;
        $display("txn a=%h b=%h as=%0b bs=%0b frac=%0b op=%0d mr=%h -> done=%0b out=%h edges=%0d busy=%0d",
                 a, b, as, bs, fr, op, mr, got, val, edges, busy_cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got=%0b want=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got=%0b want=0", done); end
        n_vec++; if (mul40_out_data !== 40'h0) begin n_err++; $display("FAIL reset_out: got=%h want=0", mul40_out_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        bit got; logic [39:0] val; logic [39:0] exp; int edges; int bc;
        run_op(16'd3, 16'd5, 1'b0, 1'b0, 1'b0, 2'b00, 40'h0, 1'b0, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL unsigned_done: got=%0b want=1 (timeout)", got); end
        n_vec++; if (edges != 18) begin n_err++; $display("FAIL unsigned_latency: got=%0d want=18", edges); end
        n_vec++; if (bc != 17) begin n_err++; $display("FAIL unsigned_busy_cycles: got=%0d want=17", bc); end
        n_vec++; if (val !== exp) begin n_err++; $display("FAIL unsigned_sb: got=%h want=%h", val, exp); end
        n_vec++; if (val !== 40'h00_0000_000F) begin n_err++; $display("FAIL unsigned_value: got=%h want=000000000f", val); end
    endtask

    task automatic test_signed();
        bit got; logic [39:0] val; logic [39:0] exp; int edges; int bc;
        logic [15:0] a; logic [15:0] b; logic [4:0] m;
        run_op(16'hFFFE, 16'h0003, 1'b1, 1'b1, 1'b0, 2'b00, 40'h0, 1'b0, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL signed_sb: got=%h done=%0b want=%h", val, got, exp); end
        n_vec++; if (val !== 40'hFF_FFFF_FFFA) begin n_err++; $display("FAIL signed_value: got=%h want=fffffffffa", val); end
        for (int i = 0; i < 10; i++) begin
            {a, b} = $urandom;
            m = 5'($urandom);
            run_op(a, b, m[0], m[1], m[2], m[4:3], {8'($urandom), $urandom}, 1'b0, 0, 0, got, val, edges, bc);
            exp = sb.pop_front();
            n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL random_%0d: got=%h done=%0b want=%h", i, val, got, exp); end
        end
    endtask

    task automatic test_frac();
        bit got; logic [39:0] val; logic [39:0] exp; int edges; int bc;
        run_op(16'h4000, 16'h4000, 1'b1, 1'b1, 1'b1, 2'b00, 40'h0, 1'b0, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL frac_half_sb: got=%h want=%h", val, exp); end
        n_vec++; if (val !== 40'h00_2000_0000) begin n_err++; $display("FAIL frac_half_value: got=%h want=0020000000", val); end
        run_op(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, 2'b00, 40'h0, 1'b0, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL frac_sat_sb: got=%h want=%h", val, exp); end
        n_vec++; if (val !== 40'h00_7FFF_FFFF) begin n_err++; $display("FAIL frac_sat_value: got=%h want=007fffffff", val); end
    endtask

    task automatic test_acc();
        bit got; logic [39:0] val; logic [39:0] exp; int edges; int bc;
        logic [39:0] want_add; logic [39:0] want_sub;
        want_add = ACC_EN ? 40'h16 : 40'h06;
        want_sub = ACC_EN ? 40'h0A : 40'h06;
        run_op(16'd2, 16'd3, 1'b0, 1'b0, 1'b0, 2'b01, 40'h10, 1'b0, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL acc_add_sb: got=%h want=%h", val, exp); end
        n_vec++; if (val !== want_add) begin n_err++; $display("FAIL acc_add_value: got=%h want=%h", val, want_add); end
        run_op(16'd2, 16'd3, 1'b0, 1'b0, 1'b0, 2'b10, 40'h10, 1'b0, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL acc_sub_sb: got=%h want=%h", val, exp); end
        n_vec++; if (val !== want_sub) begin n_err++; $display("FAIL acc_sub_value: got=%h want=%h", val, want_sub); end
        run_op(16'd2, 16'd3, 1'b0, 1'b0, 1'b0, 2'b11, 40'h10, 1'b0, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== 40'h06 || val !== exp) begin n_err++; $display("FAIL acc_op11: got=%h want=0000000006", val); end
    endtask

    task automatic test_busy_start();
        bit got; logic [39:0] val; logic [39:0] exp; int edges; int bc; bit extra;
        run_op(16'h0011, 16'h0011, 1'b0, 1'b0, 1'b0, 2'b00, 40'h0, 1'b0, 5, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL busy_start_sb: got=%h want=%h", val, exp); end
        n_vec++; if (edges != 18) begin n_err++; $display("FAIL busy_start_latency: got=%0d want=18", edges); end
        extra = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) extra = 1'b1;
        end
        n_vec++; if (extra !== 1'b0) begin n_err++; $display("FAIL busy_start_ignored: got second op=%0b want=0", extra); end
    endtask

    task automatic test_back_to_back();
        bit got; logic [39:0] val; logic [39:0] exp; int edges; int bc;
        run_op(16'h0100, 16'h0021, 1'b0, 1'b0, 1'b0, 2'b00, 40'h0, 1'b0, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL b2b_first: got=%h want=%h", val, exp); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_window: got=%0b want=1", done); end
        run_op(16'hFFFF, 16'h0002, 1'b1, 1'b0, 1'b0, 2'b00, 40'h0, 1'b1, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL b2b_second: got=%h done=%0b want=%h", val, got, exp); end
        n_vec++; if (edges != 18) begin n_err++; $display("FAIL b2b_latency: got=%0d want=18", edges); end
    endtask

    task automatic test_abort();
        bit got; logic [39:0] val; logic [39:0] exp; logic [39:0] prior; int edges; int bc;
        run_op(16'h0102, 16'h0003, 1'b0, 1'b0, 1'b0, 2'b00, 40'h0, 1'b0, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL abort_prior: got=%h want=%h", val, exp); end
        prior = exp;
        run_op(16'h7777, 16'h1234, 1'b0, 1'b0, 1'b0, 2'b00, 40'h0, 1'b0, 0, 5, got, val, edges, bc);
        n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got done=%0b want=0", got); end
        n_vec++; if (bc != 5) begin n_err++; $display("FAIL abort_busy_cycles: got=%0d want=5", bc); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got=%0b want=0", busy); end
        n_vec++; if (mul40_out_data !== prior) begin n_err++; $display("FAIL abort_out_hold: got=%h want=%h", mul40_out_data, prior); end
    endtask

    task automatic test_mid_reset();
        bit got; logic [39:0] val; logic [39:0] exp; int edges; int bc;
        @(negedge clk);
        mul_a = 16'h1234; mul_b = 16'h5678; a_signed = 1'b0; b_signed = 1'b0;
        ps_mul_IbF = 1'b0; acc_op = 2'b00; mr_in = '0; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got=%0b want=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got=%0b want=0", done); end
        n_vec++; if (mul40_out_data !== 40'h0) begin n_err++; $display("FAIL midreset_out: got=%h want=0", mul40_out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd7, 16'd9, 1'b0, 1'b0, 1'b0, 2'b00, 40'h0, 1'b0, 0, 0, got, val, edges, bc);
        exp = sb.pop_front();
        n_vec++; if (got !== 1'b1 || val !== exp) begin n_err++; $display("FAIL midreset_next_sb: got=%h want=%h", val, exp); end
        n_vec++; if (val !== 40'h00_0000_003F) begin n_err++; $display("FAIL midreset_next_value: got=%h want=000000003f", val); end
        n_vec++; if (edges != 18) begin n_err++; $display("FAIL midreset_next_latency: got=%0d want=18", edges); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        mul_a = '0; mul_b = '0; a_signed = 1'b0; b_signed = 1'b0;
        ps_mul_IbF = 1'b0; acc_op = 2'b00; mr_in = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_frac();
        test_acc();
        test_busy_start();
        test_back_to_back();
        test_abort();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 SHALL have parameter SIZE, default 16, operand width; the product/result width is SIZE*5/2 (40 at default).
REQ-002 SHALL have port clk, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, request a multiply; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit, synchronous cancel of an operation in progress.
REQ-006 SHALL have ports mul_a and mul_b, input, SIZE bits each, the operands.
REQ-007 SHALL have ports a_signed and b_signed, input, 1 bit each, two's-complement interpretation per operand.
REQ-008 SHALL have port ps_mul_IbF, input, 1 bit, fractional (1.15) mode.
REQ-009 SHALL have port acc_op, input, 2 bits: 00 plain, 01 MR plus product, 10 MR minus product, 11 same as 00.
REQ-010 SHALL have port mr_in, input, SIZE*5/2 bits, accumulator operand.
REQ-011 SHALL have port busy, output, 1 bit, operation in progress.
REQ-012 SHALL have port done, output, 1 bit, one-cycle result-valid pulse.
REQ-013 SHALL have port mul40_out_data, output, SIZE*5/2 bits, the result, registered; it feeds the rounding stage.

Function
REQ-014 SHALL capture start, mul_a, mul_b, a_signed, b_signed, ps_mul_IbF, acc_op and mr_in at the edge where start=1 in IDLE; later changes SHALL NOT affect the result.
REQ-015 SHALL implement the states IDLE, CALC and FIN; IDLE->CALC on start; CALC->FIN after exactly SIZE iterations; FIN->IDLE unconditionally.
REQ-016 SHALL in CALC form the unsigned magnitude product by radix-2 shift-add of the operand magnitudes, one bit per cycle, with a counter from 0 to SIZE-1.
REQ-017 SHALL in FIN negate the product when the effective operand signs differ, then sign-extend (signed result) or zero-extend (both unsigned) it to SIZE*5/2 bits.
REQ-018 SHALL, when ps_mul_IbF=1, shift the 2*SIZE-bit product left by one before extension.
REQ-019 SHALL, when ps_mul_IbF=1 and both operands are signed 0x8000, produce 0x7FFFFFFF sign-extended (saturated), not the wrapped value.
REQ-020 SHALL apply acc_op in FIN as a SIZE*5/2-bit add or subtract with mr_in, wrapping modulo 2^(SIZE*5/2) with no saturation.
REQ-021 SHALL keep busy=1 from the edge after start is accepted through the FIN cycle, which is SIZE+1 cycles.
REQ-022 SHALL update mul40_out_data and pulse done=1 for one cycle at the edge leaving FIN; the latency from the start edge to done=1 is SIZE+2 cycles.
REQ-023 SHALL hold mul40_out_data until the next done pulse.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL accept a start in the same cycle that done=1, because the block is in IDLE then, giving back-to-back issue.
REQ-026 SHALL, when abort=1 in CALC or FIN, return to IDLE at the next edge with no done pulse and mul40_out_data unchanged; abort in IDLE SHALL have no effect, and abort wins over start.

Reset
REQ-027 SHALL on rst_n=0 immediately force state=IDLE, counter=0, busy=0, done=0, mul40_out_data=0 and internal accumulators to 0.
REQ-028 SHALL discard an operation in progress when reset asserts mid-operation; after release the first accepted start SHALL behave normally.

Configuration
REQ-029 SHALL, when macro MUL_ITER_ACC_EN is defined, implement acc_op and mr_in as specified in REQ-020.
REQ-030 SHALL, when MUL_ITER_ACC_EN is undefined, keep the acc_op and mr_in ports but ignore them (treated as acc_op=00) and synthesize no accumulator adder; latency is unchanged.

Verification
REQ-031 SHALL verify an unsigned integer multiply: mul_a=3, mul_b=5, acc_op=00 -> done 18 cycles after start, out=0x000000000F.
REQ-032 SHALL verify a signed multiply: mul_a=0xFFFE, mul_b=0x0003, both signed -> out=0xFFFFFFFFFA.
REQ-033 SHALL verify fractional mode: 0x4000 x 0x4000, ps_mul_IbF=1, signed -> out=0x0020000000; 0x8000 x 0x8000 -> out=0x007FFFFFFF.
REQ-034 SHALL verify accumulate with MUL_ITER_ACC_EN defined: mr_in=0x10, 2x3, acc_op=01 -> 0x16; acc_op=10 -> 0x0A; with the macro undefined -> 0x06.
REQ-035 SHALL verify busy-time start, back-to-back issue and abort: start during busy -> ignored; start coincident with done -> accepted; abort in cycle 5 -> no done and out holds its prior value.
REQ-036 SHALL verify reset mid-operation: rst_n=0 in CALC cycle 8 -> busy=0, done=0, out=0 immediately; next start 7x9 -> out=0x000000003F.
